// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, branch flush, memory wait-state stall FSM and saturating perf counters.
// Optional EXE-operand forwarding is enabled by defining HAZARD_FORWARDING_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  exe_wb_en,
  input  logic                  mem_wb_en,
  input  logic                  wb_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] exe_src1,
  input  logic [REG_ADDR_W-1:0] exe_src2,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  clr_cnt,
  output logic                  hazard,
  output logic                  mem_stall,
  output logic                  flush,
  output logic [1:0]            sel_src1,
  output logic [1:0]            sel_src2,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      memwait_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  mem_state_t        state_r;
  mem_state_t        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              err_set_s;
  logic              stall_s;
  logic              raw_s;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic [CNT_W-1:0]  memwait_cnt_r;

  function automatic logic match(input logic [REG_ADDR_W-1:0] x,
                                 input logic [REG_ADDR_W-1:0] d,
                                 input logic                  en);
    return en & (x == d);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc,
                                               input logic             clr);
    logic [CNT_W-1:0] res;
    if (clr) begin
      res = {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + CNT_W'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Memory FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= mem_err_r | err_set_s;
    end
  end

  // Memory FSM next state; ready wins over timeout, a dropped request aborts silently.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    err_set_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_req && !mem_ready) begin
          state_nxt_s    = WAIT;
          wait_cnt_nxt_s = WAIT_W'(1);
        end else begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end
      end
      WAIT: begin
        if (!mem_req || mem_ready) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else if (wait_cnt_r == TIMEOUT_V) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
          err_set_s      = 1'b1;
        end else begin
          state_nxt_s    = WAIT;
          wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Memory FSM output: stall until ready, released on the timeout cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = mem_req & ~mem_ready;
      WAIT:    stall_s = mem_req & ~mem_ready & (wait_cnt_r != TIMEOUT_V);
      default: stall_s = 1'b0;
    endcase
  end

  // No freeze is requested while the pipeline is held in reset.
  assign mem_stall = stall_s & ~rst;

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time.
  assign raw_s = id_valid & exe_mem_read &
                 (match(id_src1, exe_dest, exe_wb_en) |
                  (id_two_src & match(id_src2, exe_dest, exe_wb_en)));

  assign sel_src1 = match(exe_src1, mem_dest, mem_wb_en) ? 2'd1 :
                    match(exe_src1, wb_dest, wb_wb_en)   ? 2'd2 : 2'd0;
  assign sel_src2 = match(exe_src2, mem_dest, mem_wb_en) ? 2'd1 :
                    match(exe_src2, wb_dest, wb_wb_en)   ? 2'd2 : 2'd0;
`else
  logic unused_fwd_s;

  assign raw_s = id_valid &
                 (match(id_src1, exe_dest, exe_wb_en) |
                  match(id_src1, mem_dest, mem_wb_en) |
                  (id_two_src & (match(id_src2, exe_dest, exe_wb_en) |
                                 match(id_src2, mem_dest, mem_wb_en))));

  assign sel_src1     = 2'd0;
  assign sel_src2     = 2'd0;
  assign unused_fwd_s = ^{exe_mem_read, exe_src1, exe_src2, wb_dest, wb_wb_en};
`endif

  assign hazard = raw_s & ~branch_taken & ~mem_stall;
  assign flush  = branch_taken & ~mem_stall;

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r   <= {CNT_W{1'b0}};
      flush_cnt_r   <= {CNT_W{1'b0}};
      memwait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r   <= sat_inc(stall_cnt_r, hazard, clr_cnt);
      flush_cnt_r   <= sat_inc(flush_cnt_r, flush, clr_cnt);
      memwait_cnt_r <= sat_inc(memwait_cnt_r, mem_stall, clr_cnt);
    end
  end

  assign mem_err     = mem_err_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;
  assign memwait_cnt = memwait_cnt_r;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised successor to the pipeline's hazard detection unit. Combines RAW hazard detection, optional EXE-operand forwarding, branch flush and a memory wait-state stall FSM for multi-cycle data memory. It also keeps saturating performance counters. It sits beside the ID/EXE/MEM/WB stage registers and drives their freeze/flush inputs and the EXE operand muxes.

Parameters:
REG_ADDR_W, 4, register-file address width
CNT_W, 16, width of each performance counter
MEM_TIMEOUT, 64, max wait cycles on mem_ready before forced release; must be >=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_src1, id_src2  in  REG_ADDR_W  ID source registers
id_two_src  in  1  id_src2 is used
exe_dest, mem_dest, wb_dest  in  REG_ADDR_W  destination register in each stage
exe_wb_en, mem_wb_en, wb_wb_en  in  1  writeback enable in each stage
exe_mem_read  in  1  EXE instruction is a load
exe_src1, exe_src2  in  REG_ADDR_W  sources latched in the ID/EXE register
branch_taken  in  1  EXE resolved branch taken
mem_req  in  1  MEM stage accesses memory (read or write)
mem_ready  in  1  memory completes the access this cycle
clr_cnt  in  1  synchronous clear of all counters
hazard  out  1  freeze PC and IF/ID; insert bubble into ID/EXE
mem_stall  out  1  freeze all stage registers
flush  out  1  flush IF/ID and ID/EXE
sel_src1, sel_src2  out  2  forwarding select: 0 register file, 1 MEM ALU result, 2 WB value
mem_err  out  1  sticky timeout flag
stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  performance counters

Behaviour:
- Reset: FSM to IDLE; wait counter, mem_err and all performance counters go to 0. Combinational outputs follow their inputs.
- Match rules:
  - match(x, d, en) = en & (x==d).
  - src2 matches are qualified by id_two_src.
  - Register 15 (PC) is a valid match target. No special case.
- Raw hazard, no forwarding: id_valid & (match(src, exe_dest, exe_wb_en) | match(src, mem_dest, mem_wb_en)).
- Gating: hazard = raw & !branch_taken & !mem_stall.
- flush = branch_taken & !mem_stall. A branch frozen in EXE flushes only on the cycle it advances.
- Memory FSM, states IDLE / WAIT:
  - IDLE: mem_req & !mem_ready: mem_stall=1 combinationally, move to WAIT, wait counter=1.
  - IDLE: mem_req & mem_ready: no stall (zero-wait access).
  - WAIT: mem_stall=1 while !mem_ready; wait counter increments.
  - WAIT: mem_ready: mem_stall=0 in that same cycle, go to IDLE.
  - WAIT: wait counter==MEM_TIMEOUT without mem_ready: set mem_err, mem_stall=0 that cycle, go to IDLE.
  - mem_req dropping in WAIT (should not happen): go to IDLE, no error.
- mem_err clears only on rst.
- Counters (saturate at all-ones, never wrap):
  - stall_cnt +1 per cycle with hazard=1.
  - flush_cnt +1 per cycle with flush=1.
  - memwait_cnt +1 per cycle with mem_stall=1.
  - clr_cnt has priority over increments in the same cycle.
- Latency: hazard, flush, mem_stall and sel are combinational (0 cycles). Counters update at the next clk edge.

Optional Feature:
Macro HAZARD_FORWARDING_EN.
- Defined:
  - sel_srcN = 1 if match(exe_srcN, mem_dest, mem_wb_en).
  - Else sel_srcN = 2 if match(exe_srcN, wb_dest, wb_wb_en).
  - Else sel_srcN = 0. MEM takes priority over WB.
  - raw is reduced to load-use only: id_valid & exe_mem_read & (match(src1, exe_dest, exe_wb_en) | match(src2, exe_dest, exe_wb_en)).
- Not defined: sel_src1 = sel_src2 = 0 always, full raw rule applies, and exe_src1/exe_src2 are unused.

Test Plan:
- Without forwarding: exe_dest=3, exe_wb_en=1, id_src1=3, id_valid=1 -> hazard=1; stall_cnt goes 0->1 after one edge.
- Without forwarding: id_two_src=0, id_src2=5, mem_dest=5, mem_wb_en=1 -> hazard=0. Set id_two_src=1 -> hazard=1.
- With HAZARD_FORWARDING_EN: exe_src1=2 matches mem_dest=2 and wb_dest=2, both wb_en=1 -> sel_src1=1. Load in EXE with exe_dest=4, id_src2=4, id_two_src=1 -> hazard=1.
- mem_req=1, mem_ready low for 3 cycles then high -> mem_stall=1 for exactly 3 cycles, memwait_cnt=3, FSM returns to IDLE.
- mem_req=1, mem_ready never asserted, MEM_TIMEOUT=4 -> mem_stall high 4 cycles then 0, mem_err=1 until rst; pulse rst mid-WAIT -> mem_stall=0 and mem_err=0 immediately.
- branch_taken=1 during mem_stall -> flush=0; on release -> flush=1 and hazard=0 despite a matching source.
